// File: rtl/coretest_bus_pkg.sv
// coretest_bus_pkg
// Shared types and constants for the coretest bus mux slice: bus widths,
// FSM state and access-kind encodings, local register offsets and the
// saturating increment used by the access counters.
package coretest_bus_pkg;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 32;
  localparam int OFFSET_W = 8;
  localparam int SEL_W    = 4;

  localparam logic [DATA_W-1:0] CNT_MAX = 32'hFFFF_FFFF;

  // Local register offsets under MUX_PREFIX
  localparam logic [OFFSET_W-1:0] LOCAL_ID       = 8'h00;
  localparam logic [OFFSET_W-1:0] LOCAL_NCORES   = 8'h01;
  localparam logic [OFFSET_W-1:0] LOCAL_CNT_BASE = 8'h10;
  localparam logic [OFFSET_W-1:0] LOCAL_UNMAPPED = 8'h20;
  localparam logic [OFFSET_W-1:0] LOCAL_CTRL     = 8'h30;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    KIND_CORE     = 2'd0,
    KIND_LOCAL    = 2'd1,
    KIND_UNMAPPED = 2'd2
  } kind_t;

  // Counters stick at all-ones instead of wrapping back to zero
  function automatic logic [DATA_W-1:0] satIncrement(input logic [DATA_W-1:0] value);
    return (value == CNT_MAX) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/coretest_bus_mux_if.sv
// coretest_bus_mux_if
// Master-side transaction bus of the coretest bus mux.
//   m_cs         request strobe, single cycle (master -> mux)
//   m_we         write enable               (master -> mux)
//   m_address    [15:8] prefix, [7:0] offset (master -> mux)
//   m_write_data write data                 (master -> mux)
//   m_read_data  response data              (mux -> master)
//   m_error      response error             (mux -> master)
//   m_ready      single-cycle completion    (mux -> master)
interface coretest_bus_mux_if;
  import coretest_bus_pkg::*;

  logic              m_cs;
  logic              m_we;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_write_data;
  logic [DATA_W-1:0] m_read_data;
  logic              m_error;
  logic              m_ready;

  modport master (
    output m_cs, m_we, m_address, m_write_data,
    input  m_read_data, m_error, m_ready
  );

  modport slave (
    input  m_cs, m_we, m_address, m_write_data,
    output m_read_data, m_error, m_ready
  );

endinterface

// File: rtl/coretest_bus_counter.sv
// coretest_bus_counter
// 32-bit saturating event counter. Clear wins over increment.
//   clk      system clock
//   reset    asynchronous active-high reset
//   i_inc    count one event this cycle
//   i_clr    synchronous clear
//   o_count  current count
module coretest_bus_counter
  import coretest_bus_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_inc,
  input  logic              i_clr,
  output logic [DATA_W-1:0] o_count
);

  logic [DATA_W-1:0] r_count;

  // Count register: clear has priority, increment saturates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= satIncrement(r_count);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/coretest_bus_mux.sv
// coretest_bus_mux
// Registered address decoder and response mux between the coretest master
// and NUM_CORES memory-like cores, with unmapped-address error responses and
// per-core access counters readable under MUX_PREFIX.
//   clk              system clock
//   reset            asynchronous active-high reset
//   bus              master transaction bus (slave side)
//   core_cs          one-hot core select, one cycle per core access
//   core_we          write enable, shared by all cores
//   core_address     core offset, shared
//   core_write_data  write data, shared
//   core_read_data   core i read data at [32i+31:32i]
//   core_error       per-core error
module coretest_bus_mux
  import coretest_bus_pkg::*;
#(
  parameter int                NUM_CORES   = 4,
  parameter logic [7:0]        PREFIX_BASE = 8'h00,
  parameter logic [7:0]        MUX_PREFIX  = 8'hFE,
  parameter logic [DATA_W-1:0] CORE_ID     = 32'h6d757830
) (
  input  logic                        clk,
  input  logic                        reset,
  coretest_bus_mux_if.slave           bus,
  output logic [NUM_CORES-1:0]        core_cs,
  output logic                        core_we,
  output logic [OFFSET_W-1:0]         core_address,
  output logic [DATA_W-1:0]           core_write_data,
  input  logic [NUM_CORES*DATA_W-1:0] core_read_data,
  input  logic [NUM_CORES-1:0]        core_error
);

  // Reject configurations where the local prefix overlaps a core prefix or
  // the core prefixes would wrap past 8'hFF.
  if (NUM_CORES < 1 || NUM_CORES > 16) begin : g_bad_num_cores
    $error("coretest_bus_mux: NUM_CORES must be in 1..16");
  end
  if (int'(PREFIX_BASE) + NUM_CORES > 256) begin : g_bad_prefix_range
    $error("coretest_bus_mux: core prefixes exceed 8'hFF");
  end
  if (int'(MUX_PREFIX) >= int'(PREFIX_BASE) &&
      int'(MUX_PREFIX) <= int'(PREFIX_BASE) + NUM_CORES - 1) begin : g_bad_mux_prefix
    $error("coretest_bus_mux: MUX_PREFIX overlaps core prefixes");
  end

  state_t                r_state;
  kind_t                 r_kind;
  logic [SEL_W-1:0]      r_sel;
  logic                  r_we;
  logic [OFFSET_W-1:0]   r_offset;
  logic [DATA_W-1:0]     r_wdata;
  logic [NUM_CORES-1:0]  r_coreCs;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_error;
  logic                  r_ready;

  logic [7:0]            w_prefix;
  kind_t                 w_kind;
  logic [SEL_W-1:0]      w_sel;
  logic [NUM_CORES-1:0]  w_selOneHot;
  logic [DATA_W-1:0]     w_coreRdata;
  logic                  w_coreErr;
  logic [DATA_W-1:0]     w_localRdata;
  logic [DATA_W-1:0]     w_captureData;
  logic                  w_captureErr;
  logic [NUM_CORES-1:0]  w_coreInc;
  logic                  w_unmappedInc;
  logic                  w_clr;
  logic [DATA_W-1:0]     w_coreCount [NUM_CORES];
  logic [DATA_W-1:0]     w_unmappedCount;

  assign w_prefix = bus.m_address[15:8];

  // Prefix decode of the incoming request; only used in IDLE when m_cs is seen
  always_comb begin
    w_kind = KIND_UNMAPPED;
    w_sel  = '0;
    if (w_prefix == MUX_PREFIX) begin
      w_kind = KIND_LOCAL;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_prefix == PREFIX_BASE + i[7:0]) begin
          w_kind = KIND_CORE;
          w_sel  = i[SEL_W-1:0];
        end
      end
    end
  end

  // One-hot select for the decoded core, empty for LOCAL and UNMAPPED
  always_comb begin
    w_selOneHot = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_selOneHot[i] = (w_kind == KIND_CORE) && (w_sel == i[SEL_W-1:0]);
    end
  end

  // Response of the latched core, picked from the flat read-data bus
  always_comb begin
    w_coreRdata = '0;
    w_coreErr   = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (r_sel == i[SEL_W-1:0]) begin
        w_coreRdata = core_read_data[i*DATA_W +: DATA_W];
        w_coreErr   = core_error[i];
      end
    end
  end

  // Local register read map; the control register and unknown offsets read 0
  always_comb begin
    w_localRdata = '0;
    if (r_offset == LOCAL_ID) begin
      w_localRdata = CORE_ID;
    end else if (r_offset == LOCAL_NCORES) begin
      w_localRdata = 32'(NUM_CORES);
    end else if (r_offset == LOCAL_UNMAPPED) begin
      w_localRdata = w_unmappedCount;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (r_offset == LOCAL_CNT_BASE + i[7:0]) begin
          w_localRdata = w_coreCount[i];
        end
      end
    end
  end

  // Value registered into the master response at the end of CAPTURE.
  // A local write returns 0 data; local accesses never flag an error.
  always_comb begin
    w_captureData = '0;
    w_captureErr  = 1'b0;
    case (r_kind)
      KIND_CORE: begin
        w_captureData = w_coreRdata;
        w_captureErr  = w_coreErr;
      end
      KIND_LOCAL: begin
        w_captureData = r_we ? '0 : w_localRdata;
        w_captureErr  = 1'b0;
      end
      default: begin
        w_captureData = '0;
        w_captureErr  = 1'b1;
      end
    endcase
  end

  // Counter strobes: increments land in ISSUE, the clear write in CAPTURE,
  // so the two can never collide.
  always_comb begin
    w_coreInc = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_coreInc[i] = (r_state == ST_ISSUE) && (r_kind == KIND_CORE) &&
                     (r_sel == i[SEL_W-1:0]);
    end
  end

  assign w_unmappedInc = (r_state == ST_ISSUE) && (r_kind == KIND_UNMAPPED);
  assign w_clr = (r_state == ST_CAPTURE) && (r_kind == KIND_LOCAL) && r_we &&
                 (r_offset == LOCAL_CTRL) && r_wdata[0];

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core_cnt
    coretest_bus_counter u_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_coreInc[g]),
      .i_clr   (w_clr),
      .o_count (w_coreCount[g])
    );
  end

  coretest_bus_counter u_unmapped_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_unmappedInc),
    .i_clr   (w_clr),
    .o_count (w_unmappedCount)
  );

  // Transaction FSM with registered outputs. core_cs is loaded on the
  // IDLE->ISSUE edge so it is high exactly during ISSUE; the core-side
  // request fields are latched on the same edge and held until the next
  // accepted request. m_ready pulses in the cycle after CAPTURE, and any
  // m_cs seen outside IDLE is simply dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_kind   <= KIND_CORE;
      r_sel    <= '0;
      r_we     <= 1'b0;
      r_offset <= '0;
      r_wdata  <= '0;
      r_coreCs <= '0;
      r_rdata  <= '0;
      r_error  <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_ready  <= 1'b0;
      r_coreCs <= '0;
      case (r_state)
        ST_IDLE: begin
          if (bus.m_cs) begin
            r_we     <= bus.m_we;
            r_offset <= bus.m_address[7:0];
            r_wdata  <= bus.m_write_data;
            r_kind   <= w_kind;
            r_sel    <= w_sel;
            r_coreCs <= w_selOneHot;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          r_rdata <= w_captureData;
          r_error <= w_captureErr;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign core_cs         = r_coreCs;
  assign core_we         = r_we;
  assign core_address    = r_offset;
  assign core_write_data = r_wdata;

  assign bus.m_read_data = r_rdata;
  assign bus.m_error     = r_error;
  assign bus.m_ready     = r_ready;

endmodule

// File: doc/coretest_bus_mux.md
Name: coretest_bus_mux

Overview:
- Parametrised address decoder and response mux between the coretest master and up to NUM_CORES 32-bit memory-like cores.
- Core i owns address prefix PREFIX_BASE+i in bits [15:8].
- Replaces the hand-written per-top combinational mux with a registered, handshaked transaction path.
- Adds unmapped-address error signalling and per-core access statistics, readable through a local register prefix.

Parameters:
- NUM_CORES, 4, number of core ports (1..16).
- PREFIX_BASE, 8'h00, prefix of core 0; core i uses PREFIX_BASE+i.
- MUX_PREFIX, 8'hFE, prefix of the local status registers. Must lie outside [PREFIX_BASE, PREFIX_BASE+NUM_CORES-1]; elaboration error otherwise.
- CORE_ID, 32'h6d757830, constant returned at local offset 0x00.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- m_cs  in  1  master request strobe, single cycle
- m_we  in  1  master write enable
- m_address  in  16  master address: [15:8] prefix, [7:0] core offset
- m_write_data  in  32  master write data
- m_read_data  out  32  response data, valid when m_ready=1
- m_error  out  1  response error, valid when m_ready=1
- m_ready  out  1  single-cycle completion pulse
- core_cs  out  NUM_CORES  one-hot core select
- core_we  out  1  write enable, shared by all cores
- core_address  out  8  core offset, shared
- core_write_data  out  32  write data, shared
- core_read_data  in  NUM_CORES*32  core i read data at bits [32i+31:32i]
- core_error  in  NUM_CORES  per-core error

Behaviour:
Clock and reset:
- One clock. Reset is asynchronous and active-high.
- While reset=1, every output and every register is 0 and the FSM is IDLE. This holds mid-transaction: an aborted access produces no m_ready.

FSM (IDLE, ISSUE, CAPTURE):
- IDLE: on m_cs=1, latch we, address and write_data; decode the prefix into sel and kind (CORE, LOCAL, UNMAPPED); go to ISSUE.
- ISSUE, one cycle: if kind=CORE, core_cs[sel]=1. core_we, core_address and core_write_data drive the latched values from ISSUE through CAPTURE and hold them afterwards. Go to CAPTURE.
- CAPTURE, one cycle:
  - kind=CORE: register m_read_data=core_read_data[sel], m_error=core_error[sel].
  - kind=LOCAL: local read or write.
  - kind=UNMAPPED: m_read_data=0, m_error=1.
  - Then go to IDLE.
- m_ready=1 in the cycle after CAPTURE, for exactly one cycle. m_read_data and m_error hold until the next completion.

Timing and handshake:
- Latency: m_cs at cycle T gives core_cs at T+1 and m_ready at T+3. The master may issue again in the m_ready cycle.
- m_cs while not IDLE is ignored and dropped; there is no queuing.
- core_cs is never asserted for LOCAL or UNMAPPED accesses.
- At most one core_cs bit is high, for one cycle only.

Local registers (prefix MUX_PREFIX, offset in [7:0]):
- 0x00, read: CORE_ID.
- 0x01, read: NUM_CORES, zero-extended.
- 0x10+i, read: access counter of core i, for i<NUM_CORES.
- 0x20, read: unmapped-access counter.
- 0x30, write: bit0=1 clears all counters. Reads return 0.
- Other local offsets: read 0, m_error=0; writes have no effect.
- Local accesses never set m_error.

Counters:
- 32-bit, saturating at 32'hFFFFFFFF, no wrap.
- Core i's counter increments once per CORE access in its ISSUE cycle, reads and writes alike.
- The unmapped counter increments in the ISSUE cycle of an UNMAPPED access.
- A clear write takes effect in its CAPTURE cycle. Counting and clearing never coincide, because accesses are serialised.

Decomposition:
- Package coretest_bus_pkg: FSM state encoding; kind encoding; local offsets (LOCAL_ID=8'h00, LOCAL_NCORES=8'h01, LOCAL_CNT_BASE=8'h10, LOCAL_UNMAPPED=8'h20, LOCAL_CTRL=8'h30).
- Sub-module coretest_bus_counter: 32-bit saturating counter with inc and clr inputs, clr priority, async active-high reset. Instantiated NUM_CORES+1 times.

Test Plan:
- Reset, then a read of 16'h0204 with core 2 returning 32'hCAFEF00D, error 0 -> core_cs=4'b0100 for one cycle at T+1, core_address=8'h04; m_ready at T+3 with m_read_data=32'hCAFEF00D, m_error=0.
- Write of 16'h0108 with data 32'h12345678 -> core_cs=4'b0010, core_we=1, core_write_data=32'h12345678; m_ready at T+3; the core 1 counter reads 1 at 16'hFE11.
- Read of 16'h7700 -> no core_cs; m_ready at T+3 with m_error=1, m_read_data=0; 16'hFE20 then reads 1.
- m_cs pulses at T and T+1 -> exactly one transaction and one m_ready; the second strobe is dropped.
- 3 accesses to core 0, then a write of 1 to 16'hFE30 -> 16'hFE10 reads 0; 16'hFE00 reads 32'h6d757830; 16'hFE01 reads 4.
- Assert reset during ISSUE of a core 3 read -> core_cs, m_ready and all counters go to 0 immediately; no m_ready after release; the next read completes normally.
